minmax_finder: RTL and testbench
================================

MINMAX_FINDER -- requirements
Module: minmax_finder

Interface
REQ-001 Parameter: CNT_W, 16, width of the accepted-sample counter.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; clears state and opens a new scan window.
REQ-005 sample_valid  input  1  sample_data is presented this cycle.
REQ-006 sample_data  input  32  IEEE-754 single-precision sample.
REQ-007 sample_last  input  1  qualifies the final sample of the window; meaningful only with sample_valid.
REQ-008 max  output  32  largest accepted sample; feeds the normalizer's max port.
REQ-009 min  output  32  smallest accepted sample; feeds the normalizer's min port.
REQ-010 count  output  CNT_W  number of accepted samples in the window.
REQ-011 valid  output  1  one-cycle pulse; max/min/count/empty/flat are final.
REQ-012 busy  output  1  high while a scan window is open.
REQ-013 empty  output  1  window closed with zero accepted samples.
REQ-014 flat  output  1  window closed with max equal to min (normalizer divide-by-zero warning).

Function
REQ-015 FSM states SHALL be IDLE, SCAN and DONE; all outputs SHALL be registered.
REQ-016 IDLE: busy=0; start -> SCAN; sample_valid SHALL be ignored.
REQ-017 SCAN: busy=1; sample_valid && sample_last -> DONE on the next edge.
REQ-018 DONE: valid=1 and busy=0 for exactly one cycle; unconditional -> IDLE.
REQ-019 start in any state SHALL force SCAN and clear count, max, min, empty and flat to 0; start takes priority over a simultaneous sample in the same cycle, which is discarded.
REQ-020 NaN (exponent 0xFF, mantissa != 0) SHALL be discarded: not counted and not compared; a NaN carrying sample_last still closes the window.
REQ-021 Ordering SHALL be total on non-NaN values: key = sign ? ~x : x | 0x80000000, unsigned compare; -0 < +0; +/-Inf are ordinary values.
REQ-022 First accepted sample in a window SHALL load both max and min.
REQ-023 Later accepted samples SHALL replace max only if key is strictly greater, and replace min only if key is strictly less.
REQ-024 count SHALL increment per accepted sample and saturate at all-ones; a saturated count SHALL NOT stop max/min updates.
REQ-025 On entry to DONE, empty = (count == 0); if empty, max = min = 0x00000000.
REQ-026 On entry to DONE, flat = (max == min) && !empty, compared bitwise.
REQ-027 Latency: valid SHALL assert on the edge after the cycle in which the last sample is accepted, with max, min and count already including that sample.
REQ-028 max, min, count, empty and flat SHALL hold after DONE until the next start or rst.
REQ-029 sample_valid with sample_last in the same cycle as start SHALL be ignored (REQ-019 applies).

Reset
REQ-030 rst SHALL set state = IDLE and max, min, count, valid, busy, empty and flat to 0 on the next edge.
REQ-031 rst SHALL take priority over start and sample_valid.
REQ-032 rst mid-SCAN SHALL abandon the window with no valid pulse.

Verification
REQ-033 Basic: start; samples 0x4111eb85, 0x41733333, 0x40733333 (last) -> one cycle later valid=1, max=0x41733333, min=0x40733333, count=3, empty=0, flat=0.
REQ-034 Signed and zero: samples 0xC0000000, 0x3F800000, 0x80000000, 0x00000000, 0xBF800000 (last) -> max=0x3F800000, min=0xC0000000, count=5.
REQ-035 NaN: samples 0x7FC00000, 0x490ed280, 0xFFC00001 (last) -> count=1, max=min=0x490ed280, flat=1; separate window of only 0x7FC00000 (last) -> empty=1, max=min=0, count=0.
REQ-036 Restart: start, 0x4a3d3580, 0x47629000, then start, 0x40733333 (last) -> max=min=0x40733333, count=1, exactly one valid pulse.
REQ-037 Reset mid-scan: two samples, then rst for 1 cycle -> busy=0, all outputs 0, no valid pulse; a following sample_valid SHALL be ignored until start.
REQ-038 Back-to-back: start asserted in the DONE cycle -> valid pulses once, and the new window begins cleared with busy=1 on the following cycle.

Source files
------------

// File: rtl/minmax_finder.sv
// Min/max scanner for IEEE-754 single-precision samples.
// Tracks the largest and smallest accepted samples in a window opened by
// start and closed by sample_last, using a total order on non-NaN values.
module minmax_finder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [31:0]      sample_data,
    input  logic             sample_last,
    output logic [31:0]      max,
    output logic [31:0]      min,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             busy,
    output logic             empty,
    output logic             flat
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [DATA_W-1:0]  max_n;
    logic [DATA_W-1:0]  min_n;
    logic [CNT_W-1:0]   count_n;
    logic               valid_n;
    logic               busy_n;
    logic               empty_n;
    logic               flat_n;

    // Running values including the sample presented this cycle.
    logic [DATA_W-1:0]  acc_max;
    logic [DATA_W-1:0]  acc_min;
    logic [CNT_W-1:0]   acc_cnt;
    logic               is_nan;
    logic               accept;

    // Map a float onto an unsigned key whose order is the float order; -0 < +0.
    function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? ~x : (x | 32'h8000_0000);
    endfunction

    // Accumulate the presented sample into the running max/min/count.
    always_comb begin
        acc_max = max;
        acc_min = min;
        acc_cnt = count;
        is_nan  = (sample_data[30:23] == 8'hFF) && (sample_data[22:0] != 23'd0);
        accept  = (state == SCAN) && sample_valid && !is_nan;
        if (accept) begin
            if (count == '0) begin
                acc_max = sample_data;
                acc_min = sample_data;
            end else begin
                if (order_key(sample_data) > order_key(max)) acc_max = sample_data;
                if (order_key(sample_data) < order_key(min)) acc_min = sample_data;
            end
            if (count != '1) acc_cnt = count + CNT_W'(1);
        end
    end

    // Next-state and next-output logic; start overrides everything but reset.
    always_comb begin
        state_n = state;
        max_n   = max;
        min_n   = min;
        count_n = count;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        empty_n = empty;
        flat_n  = flat;

        case (state)
            IDLE: begin
                busy_n = 1'b0;
            end
            SCAN: begin
                busy_n  = 1'b1;
                max_n   = acc_max;
                min_n   = acc_min;
                count_n = acc_cnt;
                if (sample_valid && sample_last) begin
                    state_n = DONE;
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                    empty_n = (acc_cnt == '0);
                    flat_n  = (acc_cnt != '0) && (acc_max == acc_min);
                    if (acc_cnt == '0) begin
                        max_n = '0;
                        min_n = '0;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (start) begin
            state_n = SCAN;
            max_n   = '0;
            min_n   = '0;
            count_n = '0;
            valid_n = 1'b0;
            busy_n  = 1'b1;
            empty_n = 1'b0;
            flat_n  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            max   <= '0;
            min   <= '0;
            count <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            empty <= 1'b0;
            flat  <= 1'b0;
        end else begin
            state <= state_n;
            max   <= max_n;
            min   <= min_n;
            count <= count_n;
            valid <= valid_n;
            busy  <= busy_n;
            empty <= empty_n;
            flat  <= flat_n;
        end
    end

endmodule

// File: tb/tb_minmax_finder.sv
// Self-checking bench for minmax_finder: directed vectors plus random traffic
// against a queue-based reference model, compared every cycle.
module tb_minmax_finder;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sample_valid;
    logic [31:0]      sample_data;
    logic             sample_last;
    logic [31:0]      max;
    logic [31:0]      min;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             busy;
    logic             empty;
    logic             flat;

    int n_checks;
    int n_errors;

    // Reference model state
    bit          m_open;
    logic [31:0] m_q[$];
    logic [31:0] e_max;
    logic [31:0] e_min;
    int          e_cnt;
    logic        e_valid;
    logic        e_busy;
    logic        e_empty;
    logic        e_flat;

    minmax_finder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_last  (sample_last),
        .max          (max),
        .min          (min),
        .count        (count),
        .valid        (valid),
        .busy         (busy),
        .empty        (empty),
        .flat         (flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Float comparison a < b under the total order: negatives descending by
    // magnitude, -0 below +0, positives ascending by magnitude.
    function automatic bit flt_less(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31];
        if (a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    // Recompute expected outputs from the samples collected so far.
    task automatic model_summarise();
        e_max = 32'd0;
        e_min = 32'd0;
        if (m_q.size() > 0) begin
            e_max = m_q[0];
            e_min = m_q[0];
            foreach (m_q[i]) begin
                if (flt_less(e_max, m_q[i])) e_max = m_q[i];
                if (flt_less(m_q[i], e_min)) e_min = m_q[i];
            end
        end
        e_cnt = (m_q.size() > CNT_MAX) ? CNT_MAX : m_q.size();
    endtask

    task automatic model_update(input logic r, input logic s, input logic v,
                                input logic [31:0] d, input logic l);
        if (r) begin
            m_open = 1'b0;
            m_q.delete();
            e_max = 0; e_min = 0; e_cnt = 0;
            e_valid = 0; e_busy = 0; e_empty = 0; e_flat = 0;
        end else if (s) begin
            m_open = 1'b1;
            m_q.delete();
            e_max = 0; e_min = 0; e_cnt = 0;
            e_valid = 0; e_busy = 1; e_empty = 0; e_flat = 0;
        end else begin
            e_valid = 1'b0;
            if (m_open && v) begin
                if (!is_nan(d)) m_q.push_back(d);
                model_summarise();
                if (l) begin
                    m_open  = 1'b0;
                    e_valid = 1'b1;
                    e_busy  = 1'b0;
                    e_empty = (m_q.size() == 0);
                    e_flat  = (m_q.size() != 0) && (e_max == e_min);
                end
            end
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(valid), 32'(e_valid));
        check("busy",  32'(busy),  32'(e_busy));
        check("max",   max,        e_max);
        check("min",   min,        e_min);
        check("count", 32'(count), 32'(e_cnt));
        check("empty", 32'(empty), 32'(e_empty));
        check("flat",  32'(flat),  32'(e_flat));
    endtask

    // One clock cycle: drive, let the edge happen, advance the model, compare.
    task automatic step(input logic r, input logic s, input logic v,
                        input logic [31:0] d, input logic l);
        rst = r; start = s; sample_valid = v; sample_data = d; sample_last = l;
        @(posedge clk);
        model_update(r, s, v, d, l);
        #1;
        compare_all();
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic smp(input logic [31:0] d, input logic l);
        step(1'b0, 1'b0, 1'b1, d, l);
    endtask

    task automatic do_start();
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    logic [31:0] specials [12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h7FC0_0000, 32'hFFC0_0001, 32'h3F80_0000, 32'hBF80_0000,
                     32'h0000_0001, 32'h8000_0001, 32'h7F7F_FFFF, 32'hFF7F_FFFF};

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_cycle();
        // Samples in IDLE are ignored
        smp(32'h4000_0000, 1'b1);

        // Basic window
        do_start();
        smp(32'h4111_eb85, 1'b0);
        smp(32'h4173_3333, 1'b0);
        smp(32'h4073_3333, 1'b1);
        check("basic_max",   max, 32'h4173_3333);
        check("basic_min",   min, 32'h4073_3333);
        check("basic_count", 32'(count), 32'd3);
        check("basic_valid", 32'(valid), 32'd1);
        idle_cycle();
        check("basic_hold",  max, 32'h4173_3333);
        idle_cycle();

        // Signed and zero
        do_start();
        smp(32'hC000_0000, 1'b0);
        smp(32'h3F80_0000, 1'b0);
        smp(32'h8000_0000, 1'b0);
        smp(32'h0000_0000, 1'b0);
        smp(32'hBF80_0000, 1'b1);
        check("sign_max", max, 32'h3F80_0000);
        check("sign_min", min, 32'hC000_0000);
        check("sign_count", 32'(count), 32'd5);
        idle_cycle();

        // -0 against +0 alone
        do_start();
        smp(32'h0000_0000, 1'b0);
        smp(32'h8000_0000, 1'b1);
        check("zero_max", max, 32'h0000_0000);
        check("zero_min", min, 32'h8000_0000);
        idle_cycle();

        // NaN discard, flat result
        do_start();
        smp(32'h7FC0_0000, 1'b0);
        smp(32'h490e_d280, 1'b0);
        smp(32'hFFC0_0001, 1'b1);
        check("nan_count", 32'(count), 32'd1);
        check("nan_flat",  32'(flat), 32'd1);
        check("nan_max",   max, 32'h490e_d280);
        idle_cycle();
        // Window of only NaN
        do_start();
        smp(32'h7FC0_0000, 1'b1);
        check("nan_empty", 32'(empty), 32'd1);
        check("nan_empty_max", max, 32'h0);
        idle_cycle();

        // Restart mid-window, start beats a simultaneous sample
        do_start();
        smp(32'h4a3d_3580, 1'b0);
        smp(32'h4762_9000, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h5000_0000, 1'b1);
        smp(32'h4073_3333, 1'b1);
        check("restart_max", max, 32'h4073_3333);
        check("restart_count", 32'(count), 32'd1);
        idle_cycle();
        idle_cycle();

        // Reset mid-scan, later samples ignored
        do_start();
        smp(32'h4111_eb85, 1'b0);
        smp(32'h4173_3333, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_busy", 32'(busy), 32'd0);
        smp(32'h4000_0000, 1'b0);
        smp(32'h4000_0000, 1'b1);
        check("rst_novalid", 32'(valid), 32'd0);
        idle_cycle();

        // Back-to-back: start during DONE
        do_start();
        smp(32'h3F80_0000, 1'b1);
        do_start();
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_valid", 32'(valid), 32'd0);
        smp(32'h4000_0000, 1'b1);
        idle_cycle();

        // Count saturation with max/min still updating
        do_start();
        for (int i = 0; i < 20; i++) smp(32'(32'h3F80_0000 + 32'(i) * 32'h0010_0000), 1'b0);
        smp(32'hC2C8_0000, 1'b1);
        check("sat_count", 32'(count), 32'(CNT_MAX));
        check("sat_min", min, 32'hC2C8_0000);
        idle_cycle();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic r, s, v, l;
            logic [31:0] d;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 1) == 1);
            l = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 11)] : $urandom;
            step(r, s, v, d, l);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
